// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the core's
// single-port memory bus next to main RAM. Four word registers: DATA,
// STATUS, BAUD_DIV and CTRL.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        wr_ena,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  // Control registers
  logic [DIV_W-1:0] r_baud;
  logic             r_tx_en;
  logic             r_irq_en;

  // Serializer
  state_t           r_state;
  logic [DIV_W-1:0] r_reload;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_tx;
  logic             r_irq;

  logic             w_wr;
  logic [1:0]       w_reg;
  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_tick;
  logic             w_start_ok;
  logic [7:0]       w_head;
  logic [7:0]       w_cnt8;
  logic             w_unused;

  assign w_wr       = sel & wr_ena & ena;
  assign w_reg      = addr[3:2];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE) | ~w_empty;
  assign w_tick     = (r_cnt == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_cnt8     = 8'(r_count);

  // Push/pop contract: the bus pushes whenever it writes DATA (no back-pressure;
  // a push into a full FIFO is dropped and flagged unless a pop frees a slot in
  // the same cycle), and the serializer pops only when the FIFO is non-empty.
  assign w_push     = w_wr & (w_reg == REG_DATA);
  assign w_start_ok = r_tx_en & ~w_empty;
  assign w_pop      = w_start_ok &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_tick));
  assign w_push_ok  = w_push & (~w_full | w_pop);

  // Address bits [1:0] are never decoded and only part of wr_data is stored.
  assign w_unused   = ^{addr[1:0], wr_data};

  // FIFO payload; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wr_data[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push & w_full & ~w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr & (w_reg == REG_STATUS) & wr_data[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // BAUD_DIV and CTRL register writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud   <= DIV_W'(DEFAULT_DIV);
      r_tx_en  <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr) begin
      if (w_reg == REG_BAUD) begin
        r_baud <= wr_data[DIV_W-1:0];
      end
      if (w_reg == REG_CTRL) begin
        r_tx_en  <= wr_data[0];
        r_irq_en <= wr_data[1];
      end
    end
  end

  // Serializer FSM: start bit, eight data bits LSB first, stop bit. Each bit
  // lasts r_reload+1 cycles; r_reload is captured at frame start so divisor
  // writes never disturb a frame in flight. tx is registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_reload <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head;
            r_reload <= r_baud;
            r_cnt    <= r_baud;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= r_reload;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= r_reload;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_pop) begin
              // Chain straight into the next frame with no idle gap.
              r_shift  <= w_head;
              r_reload <= r_baud;
              r_cnt    <= r_baud;
              r_tx     <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Interrupt: transmitter fully drained and enabled to signal it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
    end
  end

  // Combinational read mux; zero when not selected so responders can be ORed.
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (w_reg)
        REG_STATUS: rd_data = {16'h0000, w_cnt8, 4'h0, r_ovf, w_empty, w_full, w_busy};
        REG_BAUD:   rd_data = 32'(r_baud);
        REG_CTRL:   rd_data = {30'h0, r_irq_en, r_tx_en};
        default:    rd_data = '0;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed register/timing scenarios
// followed by randomized bursts, with a serial-line monitor that checks every
// frame against a queue of expected bytes.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        sel;
  logic [3:0]  addr;
  logic        wr_ena;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx;
  logic        irq;

  mmio_uart_tx #(
    .FIFO_DEPTH (16),
    .DIV_W      (16),
    .DEFAULT_DIV(868)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .sel    (sel),
    .addr   (addr),
    .wr_ena (wr_ena),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .tx     (tx),
    .irq    (irq)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         end_q[$];
  int         cur_div = 868;
  bit         mon_en = 1'b0;
  int         frames_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks; all called at posedge+1ns.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; ena = 1'b1; wr_ena = 1'b1; addr = a; wr_data = d;
    tick();
    sel = 1'b0; wr_ena = 1'b0; wr_data = '0; addr = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; wr_ena = 1'b0; addr = a;
    #1;
    d = rd_data;
    sel = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] v;
    bus_rd(a, v);
    check(tag, v, e);
  endtask

  task automatic set_baud(input int d);
    bus_wr(4'h8, 32'(d));
    cur_div = d;
  endtask

  // Wait until STATUS reports not busy and every expected byte has been seen.
  task automatic drain(input int max_cyc);
    logic [31:0] s;
    int n;
    n = 0;
    forever begin
      bus_rd(4'h4, s);
      if (s[0] == 1'b0 && exp_q.size() == 0) break;
      if (n >= max_cyc) begin
        check("drain_timeout", 32'(exp_q.size()) + 32'(s[0]), 32'd0);
        exp_q.delete();
        break;
      end
      tick();
      n++;
    end
  endtask

  // Serial monitor: a frame is start bit, 8 data bits LSB first, stop bit,
  // each lasting cur_div+1 cycles. Every cycle of the frame is compared.
  initial begin : monitor
    int         per;
    int         n;
    int         bad;
    int         s;
    int         idx;
    bit         have;
    bit         aborted;
    logic [7:0] eb;
    logic [7:0] rx;
    logic       lvl;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && tx === 1'b0) begin
        per = cur_div + 1;
        n = 10 * per;
        bad = 0;
        rx = '0;
        s = cyc;
        aborted = 1'b0;
        have = (exp_q.size() > 0);
        eb = have ? exp_q[0] : 8'h00;
        for (int i = 0; i < n; i++) begin
          if (i > 0) begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
              aborted = 1'b1;
              break;
            end
          end
          idx = i / per;
          if (idx == 0)      lvl = 1'b0;
          else if (idx == 9) lvl = 1'b1;
          else               lvl = eb[idx-1];
          if (tx !== lvl) bad++;
          if (idx >= 1 && idx <= 8 && (i % per) == 0) rx[idx-1] = tx;
        end
        if (!aborted) begin
          start_q.push_back(s);
          end_q.push_back(cyc);
          frames_seen++;
          check("frame_expected", 32'(have), 32'd1);
          if (have) begin
            void'(exp_q.pop_front());
            check("frame_byte", 32'(rx), 32'(eb));
            check("frame_wave_errs", 32'(bad), 32'd0);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  b;
    logic [31:0] es;
    int          f0;
    int          low_cnt;
    rst = 1'b1; ena = 1'b0; sel = 1'b0; wr_ena = 1'b0; addr = '0; wr_data = '0;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    rd_check("rst_status", 4'h4, 32'h0000_0004);
    rd_check("rst_baud", 4'h8, 32'd868);
    rd_check("rst_ctrl", 4'hC, 32'h0);
    rd_check("rst_data_reads0", 4'h0, 32'h0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    mon_en = 1'b1;

    // BAUD_DIV keeps only its low DIV_W bits
    bus_wr(4'h8, 32'hFFFF_1234);
    rd_check("baud_width", 4'h8, 32'h0000_1234);

    // Single frame 0xA5 at DIV=3, including start latency
    set_baud(3);
    bus_wr(4'hC, 32'h1);
    rd_check("ctrl_rb", 4'hC, 32'h1);
    exp_q.push_back(8'hA5);
    bus_wr(4'h0, 32'h0000_00A5);
    check("lat_pre", 32'(tx), 32'd1);
    tick();
    check("lat_start", 32'(tx), 32'd0);
    tick(2);
    rd_check("status_midframe", 4'h4, 32'h0000_0005);
    drain(100);
    rd_check("status_after_a5", 4'h4, 32'h0000_0004);
    check("a5_len", 32'(end_q[$] - start_q[$] + 1), 32'd40);
    check("tx_idle_high", 32'(tx), 32'd1);

    // Back-to-back frames at DIV=0: no idle gap
    set_baud(0);
    start_q.delete();
    end_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    bus_wr(4'h0, 32'h55);
    bus_wr(4'h0, 32'h0F);
    drain(100);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) begin
      check("b2b_no_gap", 32'(start_q[1]), 32'(end_q[0] + 1));
      check("b2b_span", 32'(end_q[1] - start_q[0] + 1), 32'd20);
    end

    // Overflow with transmitter disabled
    bus_wr(4'hC, 32'h0);
    set_baud(1);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) exp_q.push_back(b);
      bus_wr(4'h0, {24'h0, b});
    end
    rd_check("ovf_status", 4'h4, 32'h0000_100B);
    bus_wr(4'h4, 32'hFFFF_FFF7);
    rd_check("ovf_kept", 4'h4, 32'h0000_100B);
    bus_wr(4'h4, 32'h0000_0008);
    rd_check("ovf_clear", 4'h4, 32'h0000_1003);
    f0 = frames_seen;
    bus_wr(4'hC, 32'h1);
    drain(500);
    check("ovf_frames", 32'(frames_seen - f0), 32'd16);
    rd_check("ovf_done_status", 4'h4, 32'h0000_0004);

    // Interrupt timing at DIV=1
    bus_wr(4'hC, 32'h3);
    tick(2);
    check("irq_idle", 32'(irq), 32'd1);
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_wr(4'h0, {24'h0, b});
    tick(5);
    check("irq_frame", 32'(irq), 32'd0);
    tick(16);
    check("irq_stop_edge", 32'(irq), 32'd0);
    tick();
    check("irq_after", 32'(irq), 32'd1);
    drain(50);

    // Reset mid data bit 3, with a second byte still queued
    bus_wr(4'hC, 32'h1);
    set_baud(3);
    exp_q.push_back(8'h00);
    bus_wr(4'h0, 32'h00);
    bus_wr(4'h0, 32'h00);
    tick(17);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_irq", 32'(irq), 32'd0);
    exp_q.delete();
    cur_div = 868;
    rd_check("rst_mid_status", 4'h4, 32'h0000_0004);
    rd_check("rst_mid_ctrl", 4'hC, 32'h0);
    rd_check("rst_mid_baud", 4'h8, 32'd868);
    bus_wr(4'hC, 32'h1);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) low_cnt++;
      tick();
    end
    check("no_residual", 32'(low_cnt), 32'd0);

    // Unselected reads are zero; unqualified writes are ignored
    for (int a = 0; a < 4; a++) begin
      sel = 1'b0; ena = 1'b1; wr_ena = 1'($urandom_range(0, 1));
      addr = {2'(a), 2'($urandom_range(0, 3))};
      #1;
      check("nosel_rd", rd_data, 32'h0);
      wr_ena = 1'b0;
    end
    sel = 1'b0; ena = 1'b1; wr_ena = 1'b1; addr = 4'hC; wr_data = 32'h0;
    tick();
    wr_ena = 1'b0;
    rd_check("nosel_wr", 4'hC, 32'h1);
    sel = 1'b1; ena = 1'b0; wr_ena = 1'b1; addr = 4'hC; wr_data = 32'h0;
    tick();
    sel = 1'b0; wr_ena = 1'b0; ena = 1'b1;
    rd_check("noena_wr", 4'hC, 32'h1);

    // Randomized bursts
    mon_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      int  d;
      int  nb;
      int  gaps;
      bit  pre;
      bit  ie;
      d = $urandom_range(0, 4);
      nb = $urandom_range(1, 16);
      pre = 1'($urandom_range(0, 1));
      ie = 1'b0;
      gaps = 0;
      set_baud(d);
      if (pre) begin
        bus_wr(4'hC, 32'h0);
        for (int j = 0; j < nb; j++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          bus_wr(4'h0, {24'h0, b});
        end
        es = '0;
        es[15:8] = 8'(nb);
        es[1] = (nb == 16);
        es[0] = 1'b1;
        rd_check("rand_status", 4'h4, es);
        ie = 1'($urandom_range(0, 1));
        bus_wr(4'hC, {30'h0, ie, 1'b1});
      end else begin
        bus_wr(4'hC, 32'h1);
        for (int j = 0; j < nb; j++) begin
          int g;
          b = 8'($urandom);
          exp_q.push_back(b);
          bus_wr(4'h0, {24'h0, b});
          g = $urandom_range(0, 3);
          gaps += g;
          tick(g);
        end
      end
      drain(nb * 10 * (d + 1) + gaps + 60);
      rd_check("rand_idle", 4'h4, 32'h0000_0004);
      tick(2);
      check("rand_irq", 32'(irq), 32'(ie));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
